// File: rtl/int_writeback.sv
// Integer writeback merge: ALU results always take the register-file write port,
// LSU results queue in an in-order FIFO and drain on cycles the ALU leaves free.
// Write port is registered (1 cycle ALU, >=2 cycles LSU); lsu_ready_o drops while the FIFO is full.
module int_writeback #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          alu_valid_i,
  input  logic [ADDR_W-1:0]             alu_addr_i,
  input  logic [DATA_W-1:0]             alu_data_i,
  input  logic                          lsu_valid_i,
  output logic                          lsu_ready_o,
  input  logic [ADDR_W-1:0]             lsu_addr_i,
  input  logic [DATA_W-1:0]             lsu_data_i,
  output logic                          write_enable_o,
  output logic [ADDR_W-1:0]             write_addr_o,
  output logic [DATA_W-1:0]             write_data_o,
  output logic [(1<<ADDR_W)-1:0]        pending_mask_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NREG  = 1 << ADDR_W;

  // FIFO storage; a slot's live bit is only ever set while the slot is occupied,
  // so the pending mask can be formed over all slots without consulting pointers.
  logic [ADDR_W-1:0]     addr_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]     addr_d [FIFO_DEPTH];
  logic [DATA_W-1:0]     data_q [FIFO_DEPTH];
  logic [DATA_W-1:0]     data_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] live_q, live_d;
  logic [PTR_W-1:0]      wptr_q, wptr_d;
  logic [PTR_W-1:0]      rptr_q, rptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     waddr_q, waddr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;

  logic                  alu_fire;
  logic                  lsu_accept;
  logic                  push;
  logic                  pop;
  logic [NREG-1:0]       pending_mask;

  // Handshake and arbitration decisions from current state and inputs.
  always_comb begin
    alu_fire    = alu_valid_i && (alu_addr_i != '0);
    lsu_ready_o = (count_q < CNT_W'(FIFO_DEPTH));
    lsu_accept  = lsu_valid_i && lsu_ready_o;
    // Writes to register 0 complete the handshake but never occupy a slot.
    push        = lsu_accept && (lsu_addr_i != '0);
    pop         = !alu_fire && (count_q != '0);
  end

  // Next-state for the FIFO and the registered write port.
  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    live_d  = live_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;

    // A younger ALU write makes any queued LSU write to the same register stale.
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (alu_fire && (addr_q[i] == alu_addr_i)) begin
        live_d[i] = 1'b0;
      end
    end

    if (alu_fire) begin
      we_d    = 1'b1;
      waddr_d = alu_addr_i;
      wdata_d = alu_data_i;
    end else if (pop) begin
      // Killed heads still drain, occupying the port for a cycle with no write.
      we_d           = live_q[rptr_q];
      waddr_d        = addr_q[rptr_q];
      wdata_d        = data_q[rptr_q];
      live_d[rptr_q] = 1'b0;
      rptr_d         = rptr_q + PTR_W'(1);
    end

    // Push and pop never address the same slot: pop needs non-empty, push needs non-full.
    if (push) begin
      addr_d[wptr_q] = lsu_addr_i;
      data_d[wptr_q] = lsu_data_i;
      live_d[wptr_q] = !(alu_fire && (lsu_addr_i == alu_addr_i));
      wptr_d         = wptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards every queued entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      live_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      addr_q  <= addr_d;
      data_q  <= data_d;
      live_q  <= live_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  // Hazard mask: one bit per register with a live queued write.
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (live_q[i]) begin
        pending_mask[addr_q[i]] = 1'b1;
      end
    end
  end

  assign pending_mask_o = pending_mask;
  assign fifo_count_o   = count_q;
  assign write_enable_o = we_q;
  assign write_addr_o   = waddr_q;
  assign write_data_o   = wdata_q;

endmodule
